// File: rtl/mod_check_scheduler_if.sv
// Request/result bundle for mod_check_scheduler: NREQ parallel operand ports
// plus one valid/ready result port and a busy indicator.
interface mod_check_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MODULUS = 5
);
    localparam int RW = ($clog2(MODULUS) > 1) ? $clog2(MODULUS) : 1;
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IW-1:0]         res_id;
    logic [RW-1:0]         res_rem;
    logic                  res_div;
    logic                  busy;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div, busy
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div, busy
    );
endinterface

// File: rtl/mod_check_scheduler.sv
// Shared serial mod-MODULUS residue engine arbitrated among NREQ requesters.
// Define MOD_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mod_check_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MODULUS = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    mod_check_scheduler_if.slave bus
);
    localparam int RW = ($clog2(MODULUS) > 1) ? $clog2(MODULUS) : 1;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [RW-1:0]   resid_q, resid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   res_id_q, res_id_d;
    logic [RW-1:0]   res_rem_q, res_rem_d;
    logic            res_div_q, res_div_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic [RW:0]     trial;
    logic [RW-1:0]   resid_next;

`ifdef MOD_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic [IW:0]       grant_sum;
    logic [IW:0]       ptr_inc;

    // Rotating a doubled copy puts requester (ptr+k) mod NREQ at bit k.
    assign valid_dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
    assign valid_rot = valid_dbl[NREQ-1:0];

    always_comb begin
        grant_found = 1'b0;
        grant_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && valid_rot[k]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, ptr_q} + (IW+1)'(k);
            end
        end
        if (grant_sum >= (IW+1)'(NREQ)) begin
            grant_sum = grant_sum - (IW+1)'(NREQ);
        end
        grant_idx = grant_sum[IW-1:0];
        ptr_inc   = {1'b0, grant_idx} + (IW+1)'(1);
        ptr_d     = ptr_q;
        if (state_q == IDLE && grant_found) begin
            ptr_d = (ptr_inc == (IW+1)'(NREQ)) ? '0 : ptr_inc[IW-1:0];
        end
    end
`endif

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_word = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One grant at most, only in IDLE, and silenced while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (resetn && state_q == IDLE && grant_found) begin
            bus.req_ready = NREQ'(1) << grant_idx;
        end
    end

    // t = 2r + b; r < MODULUS guarantees a single subtract reduces it.
    assign trial      = {resid_q, shreg_q[WIDTH-1]};
    assign resid_next = (trial >= (RW+1)'(MODULUS)) ? RW'(trial - (RW+1)'(MODULUS))
                                                    : RW'(trial);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        resid_d     = resid_q;
        cnt_d       = cnt_q;
        res_id_d    = res_id_q;
        res_rem_d   = res_rem_q;
        res_div_d   = res_div_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    shreg_d  = grant_word;
                    resid_d  = '0;
                    cnt_d    = '0;
                    res_id_d = grant_idx;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                resid_d = resid_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_rem_d   = resid_next;
                    res_div_d   = (resid_next == '0);
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            resid_q     <= '0;
            cnt_q       <= '0;
            res_id_q    <= '0;
            res_rem_q   <= '0;
            res_div_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef MOD_SCHED_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            resid_q     <= resid_d;
            cnt_q       <= cnt_d;
            res_id_q    <= res_id_d;
            res_rem_q   <= res_rem_d;
            res_div_q   <= res_div_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
`ifndef MOD_SCHED_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_rem   = res_rem_q;
    assign bus.res_div   = res_div_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mod_check_scheduler.sv
// Randomized scoreboard bench for mod_check_scheduler, plus a WIDTH=1/MODULUS=2 instance.
module tb_mod_check_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MOD  = 5;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mod_check_scheduler_if #(.NREQ(NREQ), .WIDTH(W), .MODULUS(MOD)) b0 ();
    mod_check_scheduler_if #(.NREQ(2), .WIDTH(1), .MODULUS(2)) b1 ();

    mod_check_scheduler #(.NREQ(NREQ), .WIDTH(W), .MODULUS(MOD)) dut (
        .clk(clk), .resetn(rst_n), .bus(b0)
    );
    mod_check_scheduler #(.NREQ(2), .WIDTH(1), .MODULUS(2)) dut_w1 (
        .clk(clk), .resetn(rst_n), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which requester should win given valid bits and pointer.
    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        int p;
        p = ptr;
`ifdef MOD_SCHED_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    typedef struct {
        int id;
        int rem;
        int acc;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            e;
    bit              m_free = 1'b1;
    int              m_ptr = 0;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    bit              exp_valid;
    logic [W-1:0]    word;

    // Monitor: compares every observable output against the model each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", b0.req_ready, 0);
            check("rst_res_valid", b0.res_valid, 0);
            check("rst_res_id", b0.res_id, 0);
            check("rst_res_rem", b0.res_rem, 0);
            check("rst_res_div", b0.res_div, 0);
            check("rst_busy", b0.busy, 0);
            sb_q.delete();
            m_free = 1'b1;
            m_ptr  = 0;
        end else begin
            g       = model_grant(b0.req_valid, m_ptr);
            exp_rdy = (m_free && g >= 0) ? (NREQ'(1) << g) : '0;
            check("req_ready", b0.req_ready, exp_rdy);
            check("busy", b0.busy, !m_free);
            exp_valid = (sb_q.size() > 0) && (cyc >= sb_q[0].acc + W + 1);
            check("res_valid", b0.res_valid, exp_valid);
            if (b0.res_valid && exp_valid) begin
                check("res_id", b0.res_id, sb_q[0].id);
                check("res_rem", b0.res_rem, sb_q[0].rem);
                check("res_div", b0.res_div, (sb_q[0].rem == 0));
                if (b0.res_ready) begin
                    void'(sb_q.pop_front());
                    m_free = 1'b1;
                end
            end
            if (exp_rdy != '0) begin
                word  = b0.req_data[g*W +: W];
                e.id  = g;
                e.rem = int'(word) % MOD;
                e.acc = cyc;
                sb_q.push_back(e);
                m_free = 1'b0;
                m_ptr  = (g + 1) % NREQ;
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        b0.req_valid[id] = 1'b1;
        b0.req_data[id*W +: W] = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (b0.req_ready[id]) ok = 1'b1;
        end
        check("send_accepted", ok, 1);
        @(posedge clk); #1;
        b0.req_valid[id] = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        b0.req_valid = '0;
        b0.res_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_res_valid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (b0.res_valid) got = 1'b1;
        end
        check("res_valid_timeout", got, 1);
    endtask

    task automatic run_w1();
        logic op;
        int   t0;
        bit   got;
        for (int k = 0; k < 2; k++) begin
            op  = (k == 0);
            got = 1'b0;
            @(posedge clk); #1;
            b1.req_valid = 2'b01;
            b1.req_data  = op;
            b1.res_ready = 1'b1;
            @(negedge clk);
            check("w1_req_ready", b1.req_ready, 2'b01);
            t0 = cyc;
            @(posedge clk); #1;
            b1.req_valid = '0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (b1.res_valid) got = 1'b1;
            end
            check("w1_latency", cyc - t0, 2);
            check("w1_res_id", b1.res_id, 0);
            check("w1_res_rem", b1.res_rem, int'(op) % 2);
            check("w1_res_div", b1.res_div, (int'(op) % 2) == 0);
        end
    endtask

    initial begin
        b0.req_valid = '0;
        b0.req_data  = '0;
        b0.res_ready = 1'b1;
        b1.req_valid = '0;
        b1.req_data  = '0;
        b1.res_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed residues from requester 1.
        send(1, 8'd35);
        send(1, 8'd37);
        send(1, 8'd255);
        send(1, 8'd0);
        idle_wait(12);

        // All requesters valid: rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) b0.req_data[i*W +: W] = W'(10 * i + 3);
        b0.req_valid = '1;
        repeat (52) @(posedge clk);
        #1;
        idle_wait(12);

        // Backpressure: stall DONE for 5 cycles while another requester waits.
        b0.res_ready = 1'b0;
        send(0, 8'd123);
        b0.req_valid[2] = 1'b1;
        b0.req_data[2*W +: W] = 8'd200;
        wait_res_valid();
        repeat (5) @(posedge clk);
        #1 b0.res_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        idle_wait(12);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 1500; i++) begin
            b0.req_valid = NREQ'($urandom);
            b0.req_data  = (NREQ*W)'($urandom);
            b0.res_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        idle_wait(12);

        // Requesters 0 and 3 continuously valid.
        b0.req_data[0*W +: W] = 8'd17;
        b0.req_data[3*W +: W] = 8'd40;
        b0.req_valid = 4'b1001;
        repeat (50) @(posedge clk);
        #1;
        idle_wait(12);

        // Reset four cycles into an operation by requester 2.
        send(2, 8'd77);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        b0.req_valid = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", b0.req_ready, 4'b0001);
        repeat (30) @(posedge clk);
        #1;

        idle_wait(15);
        check("drain_empty", sb_q.size(), 0);

        run_w1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mod_check_scheduler.md
# mod_check_scheduler

Shares one serial residue (divisibility) datapath among `NREQ` requesters. Each requester presents a parallel `WIDTH`-bit word. The block arbitrates among them, serializes the granted word MSB-first through a mod-`MODULUS` remainder state machine, and returns the remainder, a divisible flag and the requester ID over a valid/ready result port. It sits between the client request ports and the result consumer, and is the only sequencer of the residue datapath.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `WIDTH`, default 8: operand width in bits; legal range 1..32.
- `MODULUS`, default 5: divisor; legal range 2..255. Derived `RW = max(1, $clog2(MODULUS))`; `IW = $clog2(NREQ)`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: bit i set means requester i holds an operand.
- `req_data` input NREQ*WIDTH: requester i's operand occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready` output NREQ: one-hot or zero; bit i set means requester i's operand is accepted this cycle.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_id` output IW: requester index of the result.
- `res_rem` output RW: operand mod `MODULUS`.
- `res_div` output 1: equals 1 when `res_rem == 0`.
- `busy` output 1: high when the state is not IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - If any `req_valid` bit is set, grant index g and assert `req_ready[g]` combinationally. Only one bit is ever asserted, and only in IDLE.
  - The grant is a valid/ready handshake. On it:
    - load `req_data[g]` into the shift register;
    - clear residue to 0 and bit counter to 0;
    - set `res_id <= g`;
    - go to SHIFT.
  - The grant is recomputed every cycle, so a requester dropping valid before acceptance is simply not served.
- **Arbitration (default round-robin)**
  - Search starts at pointer p and takes the first set `req_valid` bit at p, p+1, …, wrapping modulo `NREQ`.
  - On acceptance, p <= (g+1) mod `NREQ`.
- **SHIFT**, one bit per cycle, MSB first:
  - t = 2·r + b, computed in RW+1 bits;
  - r <= (t >= MODULUS) ? t − MODULUS : t;
  - one conditional subtract is sufficient because r < MODULUS.
  - After `WIDTH` bits, go to DONE and register `res_rem`, `res_div` and `res_valid = 1`.
- **DONE**
  - `res_valid`, `res_id`, `res_rem` and `res_div` are held stable until `res_valid && res_ready`.
  - After that handshake, go to IDLE. `res_valid` falls on the next edge.
  - No request is accepted in DONE or SHIFT; `req_ready` is all zero.
- **Reset values:** state IDLE, p = 0, `req_ready` = 0, `res_valid` = 0, `res_id` = 0, `res_rem` = 0, `res_div` = 0, `busy` = 0, residue and counter = 0.
- **Reset mid-operation:** asserting `resetn` low in SHIFT or DONE aborts the operation. No result is produced and the in-flight operand is discarded.

## Timing
- Acceptance in cycle T (IDLE).
- SHIFT occupies cycles T+1 … T+WIDTH.
- `res_valid` is high from T+WIDTH+1.
- If `res_ready` is high at T+WIDTH+1, the block is in IDLE at T+WIDTH+2 and can accept again that cycle. Minimum issue interval is WIDTH+2 cycles.
- `res_ready` low stalls DONE indefinitely. Outputs stay unchanged and `busy` stays 1.
- `res_ready` while `res_valid` = 0 is ignored.
- `WIDTH` = 1: a single SHIFT cycle, so latency is 2.

## Configuration
- `MOD_SCHED_FIXED_PRIO_EN` defined: fixed priority arbitration; the lowest set `req_valid` index always wins, and pointer p is not implemented.
- `MOD_SCHED_FIXED_PRIO_EN` undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
Defaults unless stated: `NREQ` = 4, `WIDTH` = 8, `MODULUS` = 5.
- **Residue values:** requester 1 sends 35, then 37, then 255, then 0. Results are id 1 with rem 0/div 1, rem 2/div 0, rem 0/div 1, and rem 0/div 1. `res_valid` rises exactly 9 cycles after each accept.
- **Round-robin:** all four `req_valid` held high with distinct data, `res_ready` = 1. Service order is 0, 1, 2, 3, 0. Accepts are spaced 10 cycles apart, and `req_ready` is never multi-hot.
- **Backpressure:** hold `res_ready` low for 5 cycles after `res_valid` rises. `res_*` stay stable, `busy` = 1 and `req_ready` = 0. The result completes on the cycle `res_ready` rises, and the next accept follows one cycle later.
- **Reset mid-SHIFT:** pull `resetn` low 4 cycles after an accept by requester 2. All outputs go to their reset values immediately, no result is emitted, and the next grant with all requesters valid goes to requester 0.
- **Boundary parameters:** `WIDTH` = 1, operand 1, `MODULUS` = 2 gives rem 1/div 0 with latency 2. With `MOD_SCHED_FIXED_PRIO_EN` defined and requesters 0 and 3 continuously valid, requester 0 is always granted.
